// File: rtl/cluster_tlb_cfg_axi2reg_if.sv
// Bus bundles for the TLB config bridge: the AXI4 slave port it serves and
// the single-word register bus it drives.

interface cluster_tlb_cfg_axi2reg_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6
);
  logic                          aw_valid;
  logic                          aw_ready;
  logic [AXI_ID_WIDTH-1:0]       aw_id;
  logic [AXI_ADDR_WIDTH-1:0]     aw_addr;
  logic [7:0]                    aw_len;
  logic [2:0]                    aw_size;
  logic [1:0]                    aw_burst;
  logic                          w_valid;
  logic                          w_ready;
  logic [AXI_DATA_WIDTH-1:0]     w_data;
  logic [AXI_DATA_WIDTH/8-1:0]   w_strb;
  logic                          w_last;
  logic                          b_valid;
  logic                          b_ready;
  logic [AXI_ID_WIDTH-1:0]       b_id;
  logic [1:0]                    b_resp;
  logic                          ar_valid;
  logic                          ar_ready;
  logic [AXI_ID_WIDTH-1:0]       ar_id;
  logic [AXI_ADDR_WIDTH-1:0]     ar_addr;
  logic [7:0]                    ar_len;
  logic [2:0]                    ar_size;
  logic [1:0]                    ar_burst;
  logic                          r_valid;
  logic                          r_ready;
  logic [AXI_ID_WIDTH-1:0]       r_id;
  logic [AXI_DATA_WIDTH-1:0]     r_data;
  logic [1:0]                    r_resp;
  logic                          r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

interface cluster_tlb_cfg_reg_if #(
  parameter int unsigned REG_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH     = 64
);
  logic                      req;
  logic                      we;
  logic [REG_ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   be;
  logic                      ready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      error;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, error
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, error
  );
endinterface

// File: rtl/cluster_tlb_cfg_axi2reg.sv
// AXI4 slave to single-word register bus bridge for the TLB config window.
// One transaction in flight; bursts are split into one register access per beat.

module cluster_tlb_cfg_axi2reg #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned REG_ADDR_WIDTH = 20
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  cluster_tlb_cfg_axi2reg_if.slave        axi,
  cluster_tlb_cfg_reg_if.master           regb
);

  localparam int unsigned STRB_W      = AXI_DATA_WIDTH / 8;
  localparam int unsigned MAX_SIZE    = $clog2(STRB_W);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  BURST_INCR  = 2'b01;

  if (AXI_ADDR_WIDTH != 64) begin : g_addr_width_check
    $fatal(1, "cluster_tlb_cfg_axi2reg: only AXI_ADDR_WIDTH = 64 is supported");
  end

  typedef enum logic [2:0] {IDLE, W_DATA, W_REG, W_RESP, R_REG, R_DATA} state_e;

  state_e                      state_q, state_d;
  logic                        prio_q,  prio_d;   // 0: write wins a tie, 1: read wins
  logic [AXI_ID_WIDTH-1:0]     id_q,    id_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [7:0]                  len_q,   len_d;
  logic [2:0]                  size_q,  size_d;
  logic [1:0]                  burst_q, burst_d;
  logic                        err_q,   err_d;
  logic [7:0]                  cnt_q,   cnt_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]           strb_q,  strb_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        aw_sel, ar_sel, last_beat, wlast_err;
  logic [AXI_ADDR_WIDTH-1:0]   addr_next;

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
    return (32'(size) > MAX_SIZE) || burst[1];
  endfunction

  assign aw_sel    = (state_q == IDLE) && axi.aw_valid && (!axi.ar_valid || !prio_q);
  assign ar_sel    = (state_q == IDLE) && axi.ar_valid && (!axi.aw_valid ||  prio_q);
  assign last_beat = (cnt_q == len_q);
  assign wlast_err = (axi.w_last != last_beat);
  // FIXED bursts keep the address; only INCR advances (error bursts never reach the bus).
  assign addr_next = (burst_q == BURST_INCR) ? addr_q + (AXI_ADDR_WIDTH'(1) << size_q) : addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (state_q)
      IDLE: begin
        if (aw_sel) begin
          id_d    = axi.aw_id;
          addr_d  = axi.aw_addr;
          len_d   = axi.aw_len;
          size_d  = axi.aw_size;
          burst_d = axi.aw_burst;
          err_d   = bad_req(axi.aw_size, axi.aw_burst);
          cnt_d   = '0;
          state_d = W_DATA;
        end else if (ar_sel) begin
          id_d    = axi.ar_id;
          addr_d  = axi.ar_addr;
          len_d   = axi.ar_len;
          size_d  = axi.ar_size;
          burst_d = axi.ar_burst;
          err_d   = bad_req(axi.ar_size, axi.ar_burst);
          cnt_d   = '0;
          state_d = R_REG;
        end
        // Round-robin only flips when both channels actually contended.
        if (axi.aw_valid && axi.ar_valid) prio_d = !prio_q;
      end
      W_DATA: begin
        if (axi.w_valid) begin
          wdata_d = axi.w_data;
          strb_d  = axi.w_strb;
          err_d   = err_q | wlast_err;
          if (!(err_q | wlast_err)) begin
            state_d = W_REG;
          end else if (last_beat) begin
            state_d = W_RESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_next;
          end
        end
      end
      W_REG: begin
        if (regb.ready) begin
          err_d = err_q | regb.error;
          if (last_beat) begin
            state_d = W_RESP;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_next;
            state_d = W_DATA;
          end
        end
      end
      W_RESP: begin
        if (axi.b_ready) state_d = IDLE;
      end
      R_REG: begin
        if (err_q) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
          state_d = R_DATA;
        end else if (regb.ready) begin
          rdata_d = regb.rdata;
          rresp_d = regb.error ? RESP_SLVERR : RESP_OKAY;
          state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (axi.r_ready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_next;
            state_d = R_REG;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axi.aw_ready = aw_sel;
    axi.ar_ready = ar_sel;
    axi.w_ready  = (state_q == W_DATA);
    axi.b_valid  = (state_q == W_RESP);
    axi.b_id     = id_q;
    axi.b_resp   = err_q ? RESP_SLVERR : RESP_OKAY;
    axi.r_valid  = (state_q == R_DATA);
    axi.r_id     = id_q;
    axi.r_data   = rdata_q;
    axi.r_resp   = rresp_q;
    axi.r_last   = (state_q == R_DATA) && last_beat;
    regb.req     = (state_q == W_REG) || ((state_q == R_REG) && !err_q);
    regb.we      = (state_q == W_REG);
    regb.addr    = addr_q[REG_ADDR_WIDTH-1:0];
    regb.wdata   = wdata_q;
    regb.be      = (state_q == R_REG) ? {STRB_W{1'b1}} : strb_q;
  end

endmodule

// File: tb/tb_cluster_tlb_cfg_axi2reg.sv
// Randomized scoreboard bench for cluster_tlb_cfg_axi2reg: a burst-level model
// predicts register accesses, R beats and B responses; monitors pop and compare.

module tb_cluster_tlb_cfg_axi2reg;
  localparam int AW = 64, DW = 64, IW = 6, RW = 20;
  localparam logic [63:0] BASE = 64'h0000_0010_0040_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cluster_tlb_cfg_axi2reg_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) axi ();
  cluster_tlb_cfg_reg_if #(.REG_ADDR_WIDTH(RW), .DATA_WIDTH(DW)) rb ();

  cluster_tlb_cfg_axi2reg #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .REG_ADDR_WIDTH(RW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .axi   (axi),
    .regb  (rb)
  );

  typedef struct { logic we; logic [19:0] addr; logic [63:0] wdata; logic [7:0] be; } reg_exp_t;
  typedef struct { logic [5:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_exp_t;
  typedef struct { logic [5:0] id; logic [1:0] resp; } b_exp_t;

  reg_exp_t rq[$];
  r_exp_t   rdq[$];
  b_exp_t   bq[$];

  int checks = 0, errors = 0;
  int rsp_delay = -1;
  bit err_en = 1'b0;
  logic [19:0] err_addr = '0;
  bit hold_r = 1'b0, hold_b = 1'b0;
  logic [63:0] wd [0:255];
  logic [7:0]  ws [0:255];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Beat address straight from the burst rules: FIXED repeats, INCR steps by 2^size.
  function automatic logic [63:0] beat_addr(logic [63:0] a, logic [1:0] burst, logic [2:0] size, int i);
    return (burst == 2'b00) ? a : a + 64'(i) * (64'd1 << size);
  endfunction

  task automatic predict_w(logic [5:0] id, logic [63:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    logic err;
    logic [63:0] ba;
    err = (size > 3'd3) || burst[1];
    for (int i = 0; i <= int'(len); i++) begin
      ba = beat_addr(a, burst, size, i);
      if (!err) begin
        rq.push_back('{1'b1, ba[19:0], wd[i], ws[i]});
        if (err_en && ba[19:0] == err_addr) err = 1'b1;
      end
    end
    bq.push_back('{id, err ? 2'b10 : 2'b00});
  endtask

  task automatic predict_r(logic [5:0] id, logic [63:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    logic bad, hit, last;
    logic [63:0] ba;
    bad = (size > 3'd3) || burst[1];
    for (int i = 0; i <= int'(len); i++) begin
      ba   = beat_addr(a, burst, size, i);
      last = (i == int'(len));
      if (bad) begin
        rdq.push_back('{id, 64'd0, 2'b10, last});
      end else begin
        hit = err_en && (ba[19:0] == err_addr);
        rq.push_back('{1'b0, ba[19:0], 64'd0, 8'hFF});
        rdq.push_back('{id, {44'd0, ba[19:0]}, hit ? 2'b10 : 2'b00, last});
      end
    end
  endtask

  task automatic send_aw(logic [5:0] id, logic [63:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = a;
    axi.aw_len = len; axi.aw_size = size; axi.aw_burst = burst;
    do begin @(negedge clk); n++; end while (!axi.aw_ready && n < 5000);
    if (!axi.aw_ready) chk("aw_handshake_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    axi.aw_valid = 1'b0;
  endtask

  task automatic send_ar(logic [5:0] id, logic [63:0] a, logic [7:0] len, logic [2:0] size, logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = a;
    axi.ar_len = len; axi.ar_size = size; axi.ar_burst = burst;
    do begin @(negedge clk); n++; end while (!axi.ar_ready && n < 5000);
    if (!axi.ar_ready) chk("ar_handshake_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    axi.ar_valid = 1'b0;
  endtask

  task automatic send_w(logic [7:0] len);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk); #1;
      axi.w_valid = 1'b1; axi.w_data = wd[i]; axi.w_strb = ws[i];
      axi.w_last = (i == int'(len));
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.w_ready && n < 5000);
      if (!axi.w_ready) chk("w_handshake_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      axi.w_valid = 1'b0; axi.w_last = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() + rdq.size() + bq.size()) != 0 && n < 20000) begin
      @(posedge clk); n++;
    end
    chk("drain_pending", 64'(rq.size() + rdq.size() + bq.size()), 64'd0);
    rq.delete(); rdq.delete(); bq.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic check_idle(string tag);
    chk({tag, "_aw_ready"}, 64'(axi.aw_ready), 64'd0);
    chk({tag, "_ar_ready"}, 64'(axi.ar_ready), 64'd0);
    chk({tag, "_w_ready"},  64'(axi.w_ready),  64'd0);
    chk({tag, "_b_valid"},  64'(axi.b_valid),  64'd0);
    chk({tag, "_r_valid"},  64'(axi.r_valid),  64'd0);
    chk({tag, "_r_last"},   64'(axi.r_last),   64'd0);
    chk({tag, "_r_data"},   axi.r_data,        64'd0);
    chk({tag, "_r_id"},     64'(axi.r_id),     64'd0);
    chk({tag, "_b_id"},     64'(axi.b_id),     64'd0);
    chk({tag, "_b_resp"},   64'(axi.b_resp),   64'd0);
    chk({tag, "_reg_req"},  64'(rb.req),       64'd0);
  endtask

  // Register-bus responder: variable latency, garbage data/error when not ready.
  initial begin
    int wc = -1;
    rb.ready = 1'b0; rb.rdata = '0; rb.error = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rb.ready = 1'b0; wc = -1;
      end else if (rb.ready) begin
        rb.ready = 1'b0; rb.rdata = {$urandom, $urandom}; rb.error = 1'($urandom);
      end else if (rb.req) begin
        if (wc < 0) wc = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 3));
        if (wc == 0) begin
          rb.ready = 1'b1;
          rb.rdata = {44'd0, rb.addr};
          rb.error = err_en && (rb.addr == err_addr);
          wc = -1;
        end else begin
          wc--;
        end
      end else begin
        rb.rdata = {$urandom, $urandom}; rb.error = 1'($urandom);
      end
    end
  end

  initial begin
    axi.r_ready = 1'b0; axi.b_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      axi.r_ready = hold_r ? 1'b0 : ($urandom % 4 != 0);
      axi.b_ready = hold_b ? 1'b0 : ($urandom % 3 != 0);
    end
  end

  // Monitors: compare on completed handshakes, check stability while stalled.
  reg_exp_t re; r_exp_t ree; b_exp_t be_;
  reg_exp_t reg_sv; r_exp_t r_sv; b_exp_t b_sv;
  bit reg_st = 0, r_st = 0, b_st = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      reg_st = 0; r_st = 0; b_st = 0;
    end else begin
      if (rb.req) chk("req_while_resp_valid", 64'(axi.r_valid | axi.b_valid), 64'd0);
      if (rb.req && reg_st) begin
        chk("reg_stable_addr", 64'(rb.addr), 64'(reg_sv.addr));
        chk("reg_stable_we",   64'(rb.we),   64'(reg_sv.we));
        chk("reg_stable_data", rb.wdata,     reg_sv.wdata);
      end
      if (rb.req && rb.ready) begin
        if (rq.size() == 0) chk("unexpected_reg_access", 64'(rb.addr), 64'hFFFF_FFFF);
        else begin
          re = rq.pop_front();
          chk("reg_we",   64'(rb.we),   64'(re.we));
          chk("reg_addr", 64'(rb.addr), 64'(re.addr));
          chk("reg_be",   64'(rb.be),   64'(re.be));
          if (re.we) chk("reg_wdata", rb.wdata, re.wdata);
        end
      end
      reg_st = rb.req && !rb.ready;
      reg_sv = '{rb.we, rb.addr, rb.wdata, rb.be};

      if (axi.r_valid && r_st) begin
        chk("r_stable_data", axi.r_data, r_sv.data);
        chk("r_stable_resp", 64'(axi.r_resp), 64'(r_sv.resp));
        chk("r_stable_last", 64'(axi.r_last), 64'(r_sv.last));
      end
      if (axi.r_valid && axi.r_ready) begin
        if (rdq.size() == 0) chk("unexpected_r_beat", axi.r_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          ree = rdq.pop_front();
          chk("r_id",   64'(axi.r_id),   64'(ree.id));
          chk("r_data", axi.r_data,      ree.data);
          chk("r_resp", 64'(axi.r_resp), 64'(ree.resp));
          chk("r_last", 64'(axi.r_last), 64'(ree.last));
        end
      end
      r_st = axi.r_valid && !axi.r_ready;
      r_sv = '{axi.r_id, axi.r_data, axi.r_resp, axi.r_last};

      if (axi.b_valid && b_st) chk("b_stable_resp", 64'(axi.b_resp), 64'(b_sv.resp));
      if (axi.b_valid && axi.b_ready) begin
        if (bq.size() == 0) chk("unexpected_b", 64'(axi.b_resp), 64'hFF);
        else begin
          be_ = bq.pop_front();
          chk("b_id",   64'(axi.b_id),   64'(be_.id));
          chk("b_resp", 64'(axi.b_resp), 64'(be_.resp));
        end
      end
      b_st = axi.b_valid && !axi.b_ready;
      b_sv = '{axi.b_id, axi.b_resp};
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, tmp, sv_data;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [19:0] off;
    int n, sel;
    rst_n = 1'b0;
    axi.aw_valid = 0; axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0; axi.aw_burst = '0;
    axi.w_valid = 0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 0;
    axi.ar_valid = 0; axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0; axi.ar_burst = '0;
    repeat (3) @(posedge clk); #1;
    check_idle("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention from reset: write first, then read; repeat: read first.
    wd[0] = 64'h1111_2222_3333_4444; ws[0] = 8'hFF;
    predict_w(6'h01, BASE + 64'h20, 8'd0, 3'd3, 2'b01);
    predict_r(6'h02, BASE + 64'h28, 8'd0, 3'd3, 2'b01);
    fork
      begin send_aw(6'h01, BASE + 64'h20, 8'd0, 3'd3, 2'b01); send_w(8'd0); end
      send_ar(6'h02, BASE + 64'h28, 8'd0, 3'd3, 2'b01);
    join
    drain();
    wd[0] = 64'h5555_6666_7777_8888; ws[0] = 8'h0F;
    predict_r(6'h04, BASE + 64'h38, 8'd0, 3'd3, 2'b01);
    predict_w(6'h03, BASE + 64'h30, 8'd0, 3'd3, 2'b01);
    fork
      begin send_aw(6'h03, BASE + 64'h30, 8'd0, 3'd3, 2'b01); send_w(8'd0); end
      send_ar(6'h04, BASE + 64'h38, 8'd0, 3'd3, 2'b01);
    join
    drain();

    // Single write, register answers after 2 cycles.
    rsp_delay = 2;
    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    predict_w(6'h15, BASE + 64'h10, 8'd0, 3'd3, 2'b01);
    send_aw(6'h15, BASE + 64'h10, 8'd0, 3'd3, 2'b01); send_w(8'd0);
    drain();
    rsp_delay = -1;

    // INCR read of four beats at offset 0x100.
    predict_r(6'h2A, BASE + 64'h100, 8'd3, 3'd3, 2'b01);
    send_ar(6'h2A, BASE + 64'h100, 8'd3, 3'd3, 2'b01);
    drain();

    // FIXED write: three accesses at the same offset.
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
    predict_w(6'h07, BASE + 64'h200, 8'd2, 3'd3, 2'b00);
    send_aw(6'h07, BASE + 64'h200, 8'd2, 3'd3, 2'b00); send_w(8'd2);
    drain();

    // Register error on beat 2 of 3 -> SLVERR, beat 3 not issued.
    err_en = 1'b1; err_addr = 20'h00308;
    for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    predict_w(6'h08, BASE + 64'h300, 8'd2, 3'd3, 2'b01);
    send_aw(6'h08, BASE + 64'h300, 8'd2, 3'd3, 2'b01); send_w(8'd2);
    drain();
    err_en = 1'b0;

    // WRAP read: two SLVERR beats, no register access.
    predict_r(6'h09, BASE + 64'h400, 8'd1, 3'd3, 2'b10);
    send_ar(6'h09, BASE + 64'h400, 8'd1, 3'd3, 2'b10);
    drain();

    // R backpressure for 10 cycles.
    hold_r = 1'b1;
    predict_r(6'h0A, BASE + 64'h480, 8'd1, 3'd3, 2'b01);
    send_ar(6'h0A, BASE + 64'h480, 8'd1, 3'd3, 2'b01);
    n = 0;
    while (!axi.r_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_r_valid_seen", 64'(axi.r_valid), 64'd1);
    sv_data = axi.r_data;
    repeat (10) @(negedge clk);
    chk("bp_r_data_held", axi.r_data, sv_data);
    chk("bp_r_valid_held", 64'(axi.r_valid), 64'd1);
    @(posedge clk); #1 hold_r = 1'b0;
    drain();

    // Longest burst.
    predict_r(6'h0B, BASE + 64'h8000, 8'd255, 3'd3, 2'b01);
    send_ar(6'h0B, BASE + 64'h8000, 8'd255, 3'd3, 2'b01);
    drain();

    // Random traffic.
    for (int t = 0; t < 40; t++) begin
      len  = 8'($urandom_range(0, 15));
      size = 3'($urandom_range(0, 4));
      sel  = $urandom % 8;
      burst = (sel < 2) ? 2'b00 : (sel < 7) ? 2'b01 : 2'($urandom_range(2, 3));
      off  = 20'($urandom) & ~20'((1 << size) - 1);
      a    = BASE | 64'(off);
      err_en = ($urandom % 4 == 0);
      tmp  = beat_addr(a, burst, size, $urandom_range(0, int'(len)));
      err_addr = tmp[19:0];
      if ($urandom % 2) begin
        for (int i = 0; i <= int'(len); i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        predict_w(6'($urandom), a, len, size, burst);
        send_aw(bq[$].id, a, len, size, burst); send_w(len);
      end else begin
        predict_r(6'(t), a, len, size, burst);
        send_ar(6'(t), a, len, size, burst);
      end
      drain();
    end
    err_en = 1'b0;

    // Reset in the middle of a read burst, then a clean transaction.
    predict_r(6'h11, BASE + 64'h500, 8'd7, 3'd3, 2'b01);
    send_ar(6'h11, BASE + 64'h500, 8'd7, 3'd3, 2'b01);
    repeat (12) @(posedge clk); #1;
    rst_n = 1'b0;
    rq.delete(); rdq.delete(); bq.delete();
    #1 check_idle("async_rst");
    @(negedge clk); check_idle("rst_edge");
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    wd[0] = 64'h0123_4567_89AB_CDEF; ws[0] = 8'hA5;
    predict_w(6'h12, BASE + 64'h600, 8'd0, 3'd3, 2'b01);
    send_aw(6'h12, BASE + 64'h600, 8'd0, 3'd3, 2'b01); send_w(8'd0);
    drain();
    predict_r(6'h13, BASE + 64'h608, 8'd1, 3'd3, 2'b01);
    send_ar(6'h13, BASE + 64'h608, 8'd1, 3'd3, 2'b01);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_tlb_cfg_axi2reg.md
Name: cluster_tlb_cfg_axi2reg

Overview:
AXI4 slave bridge on the cluster crossbar's C2H TLB config master port, window base+0x40_0000..0x50_0000. Converts each AXI burst into a sequence of single-word register accesses on a simple req/ready register bus, which feeds the TLB config register file. Handles one transaction at a time and arbitrates reads against writes. Returns per-beat read responses and one aggregated write response.

Parameters:
AXI_ADDR_WIDTH, 64, AXI address width (only 64 supported; elaboration $fatal otherwise)
AXI_DATA_WIDTH, 64, AXI and register data width
AXI_ID_WIDTH, 6, ID width of the crossbar master port
REG_ADDR_WIDTH, 20, register offset width (1 MiB window)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
aw_valid_i / aw_ready_o  in/out  1  AW handshake
aw_id_i  in  AXI_ID_WIDTH  write ID
aw_addr_i  in  AXI_ADDR_WIDTH  write address
aw_len_i  in  8  beats-1
aw_size_i  in  3  log2 bytes per beat
aw_burst_i  in  2  burst type
w_valid_i / w_ready_o  in/out  1  W handshake
w_data_i  in  AXI_DATA_WIDTH  write data
w_strb_i  in  AXI_DATA_WIDTH/8  write strobes
w_last_i  in  1  last beat
b_valid_o / b_ready_i  out/in  1  B handshake
b_id_o  out  AXI_ID_WIDTH  response ID
b_resp_o  out  2  write response
ar_valid_i / ar_ready_o  in/out  1  AR handshake
ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i  in  as AW  read request
r_valid_o / r_ready_i  out/in  1  R handshake
r_id_o  out  AXI_ID_WIDTH  read ID
r_data_o  out  AXI_DATA_WIDTH  read data
r_resp_o  out  2  read response
r_last_o  out  1  last read beat
reg_req_o  out  1  register access request
reg_we_o  out  1  1=write
reg_addr_o  out  REG_ADDR_WIDTH  register byte offset
reg_wdata_o  out  AXI_DATA_WIDTH  write data
reg_be_o  out  AXI_DATA_WIDTH/8  byte enables
reg_ready_i  in  1  access complete this cycle
reg_rdata_i  in  AXI_DATA_WIDTH  read data, valid with reg_ready_i
reg_error_i  in  1  access error, valid with reg_ready_i

Behaviour:
- One clock clk_i; reset rst_ni asynchronous, active-low.
- Reset: all valid/ready/req outputs 0, all data/ID/addr/resp outputs 0, FSM IDLE, priority bit = write-first.
- FSM: IDLE, W_DATA, W_REG, W_RESP, R_REG, R_DATA.
- IDLE: aw_ready_o=ar_ready_o=0 unless selected. One of aw/ar valid -> accept it. Both valid -> accept the one with priority, then toggle priority (round-robin). Accept = ready high one cycle, latch id, addr, len, size, burst. Go to W_DATA or R_REG.
- Error check at accept: size > log2(AXI_DATA_WIDTH/8) or burst==WRAP (2'b10) or burst==2'b11 -> error flag set. All beats still consumed/produced, but no register access is issued.
- Beat address: FIXED -> constant; INCR -> addr += 2^size per beat, full AXI_ADDR_WIDTH add. reg_addr_o = addr[REG_ADDR_WIDTH-1:0].
- W_DATA: w_ready_o=1. On w handshake, capture data/strb and go to W_REG; if error flag is set, skip W_REG.
- W_REG: reg_req_o=1, reg_we_o=1, reg_be_o=strb; all held stable until reg_ready_i. On reg_ready_i, OR reg_error_i into the error flag. Then next beat -> W_DATA, last beat -> W_RESP.
- Last beat = beat counter == len. w_last_i is ignored for sequencing; if w_last_i mismatches the counter, the error flag is set.
- W_RESP: b_valid_o=1, b_id_o=latched id, b_resp_o = error ? SLVERR(2'b10) : OKAY. Hold until b_ready_i, then go to IDLE.
- R_REG: reg_req_o=1, reg_we_o=0, reg_be_o all ones. Held until reg_ready_i, then capture rdata and error into the R register and go to R_DATA. If the error flag is set, skip the access: data 0, resp SLVERR.
- R_DATA: r_valid_o=1, r_last_o = (counter==len), r_resp_o per beat. Hold stable until r_ready_i. Then next beat -> R_REG, last beat -> IDLE.
- reg_req_o is never asserted while r_valid_o or b_valid_o is high; at most one register access is outstanding.
- len=255 is supported; 8-bit beat counter, no overflow.
- Backpressure: any number of stall cycles on reg_ready_i, r_ready_i or b_ready_i. Outputs stay stable throughout.
- Reset mid-burst: state discarded immediately; no response is issued for the aborted transaction.
- Throughput: single-beat write takes ≥4 cycles from AW accept to B valid; single-beat read takes ≥3 cycles from AR accept to R valid.

Test Plan:
- Single write: AW addr=base+0x40_0010, len=0, size=3, INCR, data=0xDEADBEEF_CAFEF00D, strb=0xFF, reg_ready after 2 cycles -> reg_addr_o=0x00010, reg_be_o=0xFF, one reg_req, b_resp=OKAY, b_id=aw_id.
- INCR read burst: len=3, size=3, addr offset 0x100, reg_rdata = offset -> 4 R beats with data 0x100,0x108,0x110,0x118; r_last only on beat 4; r_id matches.
- FIXED burst write: len=2 -> three reg writes, all at the same offset.
- Error path: reg_error_i on beat 2 of a 3-beat write -> b_resp=SLVERR. WRAP read with len=1 -> 2 SLVERR beats with data 0 and no reg_req.
- Arbitration: AW and AR valid in the same cycle from reset -> write served first, then read. Repeat -> read served first.
- Backpressure/reset: hold r_ready_i=0 for 10 cycles -> r_* stable. Assert rst_ni low mid-burst -> all outputs 0 next edge, clean transaction afterward.
